// File: rtl/diffeq_pkg.sv
// Shared types for the iterating diffeq HLSM: state encoding, iteration-counter sizing
// and the per-state datapath schedule (which registers load in LOAD and S1..S5).
package diffeq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        S1    = 3'd2,
        S2    = 3'd3,
        S3    = 3'd4,
        S4    = 3'd5,
        S5    = 3'd6,
        FINAL = 3'd7
    } state_e;

    typedef struct packed {
        logic ld;
        logic s1;
        logic s2;
        logic s3;
        logic s4;
        logic s5;
    } step_en_t;

    // At most two multipliers and one adder/subtractor are scheduled per step.
    localparam step_en_t SCHED_NONE = '{default: 1'b0};
    localparam step_en_t SCHED_LD   = '{ld: 1'b1, default: 1'b0};
    localparam step_en_t SCHED_S1   = '{s1: 1'b1, default: 1'b0};
    localparam step_en_t SCHED_S2   = '{s2: 1'b1, default: 1'b0};
    localparam step_en_t SCHED_S3   = '{s3: 1'b1, default: 1'b0};
    localparam step_en_t SCHED_S4   = '{s4: 1'b1, default: 1'b0};
    localparam step_en_t SCHED_S5   = '{s5: 1'b1, default: 1'b0};

    function automatic int unsigned iter_w(input int unsigned max_iter);
        return $clog2(max_iter + 1);
    endfunction

    function automatic step_en_t sched(input state_e st);
        step_en_t en;
        en = SCHED_NONE;
        case (st)
            LOAD:    en = SCHED_LD;
            S1:      en = SCHED_S1;
            S2:      en = SCHED_S2;
            S3:      en = SCHED_S3;
            S4:      en = SCHED_S4;
            S5:      en = SCHED_S5;
            default: en = SCHED_NONE;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/diffeq_step.sv
// Datapath for one diffeq iteration: operand latches, working registers and temporaries t1..t6,
// each loaded only in its scheduled step. Loads on the edge ending the enabled state; no backpressure.
module diffeq_step
    import diffeq_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  step_en_t                    en_i,
    input  logic signed [DATAWIDTH-1:0] u_i,
    input  logic signed [DATAWIDTH-1:0] x_i,
    input  logic signed [DATAWIDTH-1:0] y_i,
    input  logic signed [DATAWIDTH-1:0] dx_i,
    input  logic signed [DATAWIDTH-1:0] a_i,
    input  logic signed [DATAWIDTH-1:0] three_i,
    output logic signed [DATAWIDTH-1:0] u_nxt_o,
    output logic signed [DATAWIDTH-1:0] xn_o,
    output logic signed [DATAWIDTH-1:0] yn_o,
    output logic                        xn_lt_a_o
);

    logic signed [DATAWIDTH-1:0] ur_q, xr_q, yr_q, dx_q, a_q, three_q;
    logic signed [DATAWIDTH-1:0] t1_q, t2_q, t3_q, t4_q, t5_q, t6_q, xn_q, yn_q;
    logic signed [DATAWIDTH-1:0] ur_d;

    assign ur_d      = t6_q - t5_q;
    assign u_nxt_o   = ur_d;
    assign xn_o      = xn_q;
    assign yn_o      = yn_q;
    assign xn_lt_a_o = (xn_q < a_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ur_q    <= '0;
            xr_q    <= '0;
            yr_q    <= '0;
            dx_q    <= '0;
            a_q     <= '0;
            three_q <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            t3_q    <= '0;
            t4_q    <= '0;
            t5_q    <= '0;
            t6_q    <= '0;
            xn_q    <= '0;
            yn_q    <= '0;
        end else begin
            // dx, a and three are captured too so operand changes after LOAD have no effect.
            if (en_i.ld) begin
                ur_q    <= u_i;
                xr_q    <= x_i;
                yr_q    <= y_i;
                dx_q    <= dx_i;
                a_q     <= a_i;
                three_q <= three_i;
            end
            if (en_i.s1) begin
                t1_q <= ur_q * dx_q;
                t2_q <= three_q * xr_q;
                xn_q <= xr_q + dx_q;
            end
            if (en_i.s2) begin
                t3_q <= t1_q * t2_q;
                t4_q <= three_q * yr_q;
            end
            if (en_i.s3) begin
                t5_q <= t4_q * dx_q;
                yn_q <= yr_q + t1_q;
            end
            if (en_i.s4) begin
                t6_q <= ur_q - t3_q;
            end
            if (en_i.s5) begin
                ur_q <= ur_d;
                xr_q <= xn_q;
                yr_q <= yn_q;
            end
        end
    end

endmodule

// File: rtl/diffeq_loop_hlsm.sv
// Iterating diffeq HLSM behind a Start/Done handshake; Done pulses 1+5N cycles after Start is taken,
// Start is ignored while Busy. Optional iteration guard compiled in with DIFFEQ_ITER_GUARD_EN.
module diffeq_loop_hlsm
    import diffeq_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int MAX_ITER  = 16
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Start,
    input  logic signed [DATAWIDTH-1:0] u,
    input  logic signed [DATAWIDTH-1:0] x,
    input  logic signed [DATAWIDTH-1:0] y,
    input  logic signed [DATAWIDTH-1:0] dx,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] three,
    output logic signed [DATAWIDTH-1:0] u1,
    output logic signed [DATAWIDTH-1:0] x1,
    output logic signed [DATAWIDTH-1:0] y1,
    output logic                        c,
    output logic                        Done,
    output logic                        Busy,
    output logic                        Timeout
);

    if (DATAWIDTH < 2) begin : g_bad_width
        $error("diffeq_loop_hlsm: DATAWIDTH must be at least 2");
    end
    if (MAX_ITER < 1) begin : g_bad_iter
        $error("diffeq_loop_hlsm: MAX_ITER must be at least 1");
    end

    state_e                      state_q;
    logic signed [DATAWIDTH-1:0] u1_q, x1_q, y1_q;
    logic                        c_q, done_q, busy_q;
    logic signed [DATAWIDTH-1:0] u_nxt, xn, yn;
    logic                        xn_lt_a;
    logic                        trip;

    diffeq_step #(
        .DATAWIDTH (DATAWIDTH)
    ) u_step (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .en_i      (sched(state_q)),
        .u_i       (u),
        .x_i       (x),
        .y_i       (y),
        .dx_i      (dx),
        .a_i       (a),
        .three_i   (three),
        .u_nxt_o   (u_nxt),
        .xn_o      (xn),
        .yn_o      (yn),
        .xn_lt_a_o (xn_lt_a)
    );

`ifdef DIFFEQ_ITER_GUARD_EN
    localparam int unsigned ITER_W = iter_w(MAX_ITER);
    logic [ITER_W-1:0] iter_q;
    logic [ITER_W-1:0] iter_inc;
    logic              timeout_q;

    assign iter_inc = iter_q + ITER_W'(1);
    assign trip     = (iter_inc == ITER_W'(MAX_ITER)) && xn_lt_a;
    assign Timeout  = timeout_q;
`else
    assign trip    = 1'b0;
    assign Timeout = 1'b0;
`endif

    assign u1   = u1_q;
    assign x1   = x1_q;
    assign y1   = y1_q;
    assign c    = c_q;
    assign Done = done_q;
    assign Busy = busy_q;

    // Results are captured on the edge entering FINAL so they are valid alongside Done.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            u1_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            c_q     <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DIFFEQ_ITER_GUARD_EN
            iter_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
`ifdef DIFFEQ_ITER_GUARD_EN
                    iter_q    <= '0;
                    timeout_q <= 1'b0;
`endif
                    if (x < a) begin
                        state_q <= S1;
                    end else begin
                        state_q <= FINAL;
                        done_q  <= 1'b1;
                        u1_q    <= u;
                        x1_q    <= x;
                        y1_q    <= y;
                        c_q     <= 1'b0;
                    end
                end
                S1: state_q <= S2;
                S2: state_q <= S3;
                S3: state_q <= S4;
                S4: state_q <= S5;
                S5: begin
`ifdef DIFFEQ_ITER_GUARD_EN
                    iter_q <= iter_inc;
                    if (trip) begin
                        timeout_q <= 1'b1;
                    end
`endif
                    if (xn_lt_a && !trip) begin
                        state_q <= S1;
                    end else begin
                        state_q <= FINAL;
                        done_q  <= 1'b1;
                        u1_q    <= u_nxt;
                        x1_q    <= xn;
                        y1_q    <= yn;
                        c_q     <= xn_lt_a;
                    end
                end
                FINAL: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
